// File: rtl/stepper_motor_control_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp and
// enables the stepper drive only when both match the compiled-in values.
module stepper_motor_control_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0400_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h545A_70F2,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        av_address,
    output logic        av_read,
    input  logic [31:0] av_readdata,
    input  logic        av_waitrequest,
    input  logic        start,
    output logic        busy,
    output logic        id_ok,
    output logic        mismatch,
    output logic        timeout,
    output logic        motor_enable,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);
    localparam logic [3:0] RetryMax   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StReadId,
        StReadTs,
        StCompare,
        StPass,
        StFail
    } state_e;

    state_e      state_q;
    logic        av_address_q;
    logic        av_read_q;
    logic        busy_q;
    logic        id_ok_q;
    logic        mismatch_q;
    logic        timeout_q;
    logic [31:0] id_value_q;
    logic [31:0] ts_value_q;
    logic [7:0]  stall_q;
    logic [3:0]  retry_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StReadId;
            av_address_q <= 1'b0;
            av_read_q    <= 1'b0;
            busy_q       <= 1'b1;
            id_ok_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            timeout_q    <= 1'b0;
            id_value_q   <= '0;
            ts_value_q   <= '0;
            stall_q      <= '0;
            retry_q      <= '0;
        end else begin
            unique case (state_q)
                StReadId, StReadTs: begin
                    if (!av_read_q) begin
                        // Issue (or re-issue after a timeout gap) the read strobe.
                        av_read_q    <= 1'b1;
                        av_address_q <= (state_q == StReadTs);
                    end else if (!av_waitrequest) begin
                        stall_q <= '0;
                        if (state_q == StReadId) begin
                            id_value_q   <= av_readdata;
                            av_address_q <= 1'b1;
                            state_q      <= StReadTs;
                        end else begin
                            ts_value_q   <= av_readdata;
                            av_read_q    <= 1'b0;
                            av_address_q <= 1'b0;
                            state_q      <= StCompare;
                        end
                    end else if (stall_q == TimeoutCnt) begin
                        stall_q      <= '0;
                        av_read_q    <= 1'b0;
                        av_address_q <= 1'b0;
                        if (retry_q < RetryMax) begin
                            retry_q <= retry_q + 4'd1;
                            state_q <= StReadId;
                        end else begin
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= StFail;
                        end
                    end else begin
                        stall_q <= stall_q + 8'd1;
                    end
                end
                StCompare: begin
                    busy_q <= 1'b0;
                    if (id_value_q == EXPECTED_ID && ts_value_q == EXPECTED_TIMESTAMP) begin
                        id_ok_q <= 1'b1;
                        state_q <= StPass;
                    end else begin
                        mismatch_q <= 1'b1;
                        state_q    <= StFail;
                    end
                end
                StPass, StFail: begin
                    if (start) begin
                        id_ok_q    <= 1'b0;
                        mismatch_q <= 1'b0;
                        timeout_q  <= 1'b0;
                        retry_q    <= '0;
                        stall_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StReadId;
                    end
                end
                default: state_q <= StReadId;
            endcase
        end
    end

    assign av_address      = av_address_q;
    assign av_read         = av_read_q;
    assign busy            = busy_q;
    assign id_ok           = id_ok_q;
    assign mismatch        = mismatch_q;
    assign timeout         = timeout_q;
    assign motor_enable    = id_ok_q;
    assign id_value        = id_value_q;
    assign timestamp_value = ts_value_q;

endmodule

// File: tb/tb_stepper_motor_control_sysid_checker.sv
// Directed bench: nominal pass, mismatch, stall, timeout/retry, re-check and mid-run reset.
module tb_stepper_motor_control_sysid_checker;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic        start = 1'b0;
    logic        av_waitrequest = 1'b0;
    logic [31:0] id_src = 32'h0400_0000;
    logic [31:0] ts_src = 32'h545A_70F2;

    logic        av_address, av_read, busy, id_ok, mismatch, timeout, motor_enable;
    logic [31:0] av_readdata, id_value, timestamp_value;

    logic        t_address, t_read, t_busy, t_id_ok, t_mismatch, t_timeout, t_motor;
    logic [31:0] t_id_value, t_ts_value;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign av_readdata = av_address ? ts_src : id_src;

    stepper_motor_control_sysid_checker dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .av_address     (av_address),
        .av_read        (av_read),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .start          (start),
        .busy           (busy),
        .id_ok          (id_ok),
        .mismatch       (mismatch),
        .timeout        (timeout),
        .motor_enable   (motor_enable),
        .id_value       (id_value),
        .timestamp_value(timestamp_value)
    );

    // Second instance with a permanently stalled slave for the timeout path.
    stepper_motor_control_sysid_checker #(
        .TIMEOUT_CYCLES(4),
        .MAX_RETRIES   (1)
    ) dut_to (
        .clock          (clock),
        .reset_n        (rst2_n),
        .av_address     (t_address),
        .av_read        (t_read),
        .av_readdata    (32'h0400_0000),
        .av_waitrequest (1'b1),
        .start          (1'b0),
        .busy           (t_busy),
        .id_ok          (t_id_ok),
        .mismatch       (t_mismatch),
        .timeout        (t_timeout),
        .motor_enable   (t_motor),
        .id_value       (t_id_value),
        .timestamp_value(t_ts_value)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_av_read", 32'(av_read), 0);
        check("rst_av_address", 32'(av_address), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_id_ok", 32'(id_ok), 0);
        check("rst_motor", 32'(motor_enable), 0);
        check("rst_mismatch", 32'(mismatch), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_id_value", id_value, 0);
        check("rst_ts_value", timestamp_value, 0);

        // Nominal zero-wait pass
        tick();
        reset_n = 1'b1;
        tick();
        check("c0_av_read", 32'(av_read), 1);
        check("c0_av_address", 32'(av_address), 0);
        check("c0_busy", 32'(busy), 1);
        tick();
        check("c1_av_read", 32'(av_read), 1);
        check("c1_av_address", 32'(av_address), 1);
        check("c1_id_value", id_value, 32'h0400_0000);
        tick();
        check("c2_av_read", 32'(av_read), 0);
        check("c2_id_ok", 32'(id_ok), 0);
        tick();
        check("c3_id_ok", 32'(id_ok), 1);
        check("c3_motor", 32'(motor_enable), 1);
        check("c3_busy", 32'(busy), 0);
        check("c3_ts_value", timestamp_value, 32'h545A_70F2);

        // Re-check with wrong ID; start during READ_TS is ignored
        id_src = 32'h0400_0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_motor_drop", 32'(motor_enable), 0);
        check("rs_busy", 32'(busy), 1);
        tick();
        check("rs_c0_av_read", 32'(av_read), 1);
        tick();
        check("rs_c1_av_address", 32'(av_address), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_c2_busy", 32'(busy), 1);
        check("rs_c2_mismatch", 32'(mismatch), 0);
        tick();
        check("rs_c3_mismatch", 32'(mismatch), 1);
        check("rs_c3_motor", 32'(motor_enable), 0);
        check("rs_c3_busy", 32'(busy), 0);
        check("rs_c3_id_value", id_value, 32'h0400_0001);

        // Timestamp mismatch, no retry
        id_src = 32'h0400_0000;
        ts_src = 32'h0000_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("tm_mismatch_clr", 32'(mismatch), 0);
        tick();
        tick();
        tick();
        tick();
        check("tm_mismatch", 32'(mismatch), 1);
        check("tm_motor", 32'(motor_enable), 0);
        check("tm_ts_value", timestamp_value, 0);
        check("tm_timeout", 32'(timeout), 0);
        tick();
        tick();
        check("tm_no_retry", 32'(av_read), 0);
        check("tm_hold", 32'(busy), 0);

        // Five stalled cycles on word 1 -> PASS at cycle 8
        ts_src = 32'h545A_70F2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("st_c0_av_read", 32'(av_read), 1);
        tick();
        av_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("st_read_hold", 32'(av_read), 1);
            check("st_addr_hold", 32'(av_address), 1);
        end
        av_waitrequest = 1'b0;
        tick();
        check("st_c7_id_ok", 32'(id_ok), 0);
        tick();
        check("st_c8_id_ok", 32'(id_ok), 1);
        check("st_c8_ts", timestamp_value, 32'h545A_70F2);

        // Reset pulsed during READ_TS
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("rr_in_ts", 32'(av_address), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rr_av_read_async", 32'(av_read), 0);
        check("rr_av_address", 32'(av_address), 0);
        check("rr_busy", 32'(busy), 1);
        check("rr_id_value", id_value, 0);
        check("rr_ts_value", timestamp_value, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("rr_c2_id_ok", 32'(id_ok), 0);
        tick();
        check("rr_c3_id_ok", 32'(id_ok), 1);
        check("rr_c3_motor", 32'(motor_enable), 1);

        // Stuck slave: two attempts, one-cycle gap, then timeout
        rst2_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            check($sformatf("to_av_read_c%0d", c), 32'(t_read),
                  ((c <= 4) || (c >= 6 && c <= 10)) ? 32'd1 : 32'd0);
            if (c == 10) check("to_busy_c10", 32'(t_busy), 1);
            if (c == 11) begin
                check("to_timeout", 32'(t_timeout), 1);
                check("to_mismatch", 32'(t_mismatch), 0);
                check("to_busy", 32'(t_busy), 0);
                check("to_motor", 32'(t_motor), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
